// File: rtl/mu0_mem_responder.sv
// ---------------------------------------------------------------------------
// mu0_mem_responder
//
// Memory-side target for the MU0 controller's memrq/rnw bus. It serves
// instruction fetches, operand reads and stores from an internal word array.
// Each transfer takes a programmable number of wait states, and completion is
// signalled with a one-cycle ready pulse. A side load port lets a program be
// written into the array while the responder is idle.
//
// Parameters
//   AW     address width in words
//   DW     data word width
//   DEPTH  implemented words; addresses >= DEPTH are out of range
//   WAIT   wait cycles inserted per transfer (0..7)
//
// Ports
//   clk      system clock, rising-edge
//   reset    asynchronous active-low reset
//   memrq    transfer request (level), sampled in IDLE
//   rnw      1 = read, 0 = write, sampled with memrq
//   addr     word address, sampled with memrq
//   wdata    write data, sampled with memrq
//   rdata    registered read data; changes only when a read completes
//   ready    one-cycle pulse: transfer complete
//   err      one-cycle pulse with ready: address out of range
//   busy     high whenever the FSM is not IDLE
//   ld_en    loader write strobe (honoured only in IDLE, wins over memrq)
//   ld_addr  loader address
//   ld_data  loader data
// ---------------------------------------------------------------------------
module mu0_mem_responder #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 4096,
  parameter int WAIT  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memrq,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic          busy,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  // Array index width; DEPTH is assumed not to exceed 2**AW.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Counter load value on entering WAIT; unused when WAIT == 0.
  localparam logic [2:0] WAIT_INIT = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic            rnw_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            addr_ok;
  logic            ld_ok;

  // Range check on the full address, so aliases above DEPTH never reach
  // the truncated array index.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {{(32-AW){1'b0}}, a} < 32'(DEPTH);
  endfunction

  assign addr_ok = in_range(addr_q);
  assign ld_ok   = in_range(ld_addr);

  // Control FSM. Outputs are registered: ready/err are set on the edge that
  // leaves RESP, so they are visible in the following IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; these
      // defaults are overridden by any later assignment in the same edge.
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load in the same cycle takes priority; memrq is left pending
          // and, if still high, is accepted on the next edge.
          if (!ld_en && memrq) begin
            rnw_q   <= rnw;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (WAIT == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        S_RESP: begin
          ready <= 1'b1;
          err   <= ~addr_ok;
          if (rnw_q) rdata <= addr_ok ? mem[addr_q[IW-1:0]] : '0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive reset, and a transfer
  // aborted by reset never reaches RESP, so its write is dropped.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && ld_en && ld_ok) begin
      mem[ld_addr[IW-1:0]] <= ld_data;
    end else if (state == S_RESP && !rnw_q && addr_ok) begin
      mem[addr_q[IW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mu0_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mu0_mem_responder
//
// Three responder instances share one clock:
//   u0: WAIT=1, DEPTH=4096
//   u1: WAIT=0, DEPTH=2048
//   u2: WAIT=3, DEPTH=4096
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// read results are pushed to a scoreboard queue when a transfer is issued and
// popped when ready is seen.
// ---------------------------------------------------------------------------
module tb_mu0_mem_responder;

  localparam int N = 3;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rnw;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset   [N];
  logic        memrq   [N];
  logic        rnw     [N];
  logic [11:0] addr    [N];
  logic [15:0] wdata   [N];
  logic [15:0] rdata   [N];
  logic        ready   [N];
  logic        err     [N];
  logic        busy    [N];
  logic        ld_en   [N];
  logic [11:0] ld_addr [N];
  logic [15:0] ld_data [N];

  int waits [N] = '{1, 0, 3};

  exp_t sbq[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  mu0_mem_responder #(.AW(12), .DW(16), .DEPTH(4096), .WAIT(1)) u0 (
    .clk(clk), .reset(reset[0]), .memrq(memrq[0]), .rnw(rnw[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
    .err(err[0]), .busy(busy[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0])
  );

  mu0_mem_responder #(.AW(12), .DW(16), .DEPTH(2048), .WAIT(0)) u1 (
    .clk(clk), .reset(reset[1]), .memrq(memrq[1]), .rnw(rnw[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
    .err(err[1]), .busy(busy[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]),
    .ld_data(ld_data[1])
  );

  mu0_mem_responder #(.AW(12), .DW(16), .DEPTH(4096), .WAIT(3)) u2 (
    .clk(clk), .reset(reset[2]), .memrq(memrq[2]), .rnw(rnw[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]),
    .err(err[2]), .busy(busy[2]), .ld_en(ld_en[2]), .ld_addr(ld_addr[2]),
    .ld_data(ld_data[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Single loader write; called and returns on a falling edge.
  task automatic load(input int i, input logic [11:0] a, input logic [15:0] d);
    ld_en[i]   = 1'b1;
    ld_addr[i] = a;
    ld_data[i] = d;
    @(negedge clk);
    ld_en[i]   = 1'b0;
  endtask

  // One transfer with memrq dropped right after it is sampled. Checks
  // latency, busy duration, result from the scoreboard and single-cycle ready.
  task automatic xfer(input int i, input logic r, input logic [11:0] a,
                      input logic [15:0] d, input logic [15:0] ed,
                      input logic ee, input string name);
    exp_t e;
    int   cyc;
    int   busy_cyc;
    sbq.push_back('{ed, ee});
    memrq[i] = 1'b1;
    rnw[i]   = r;
    addr[i]  = a;
    wdata[i] = d;
    @(negedge clk);
    memrq[i] = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    while (!ready[i] && cyc < 20) begin
      if (busy[i]) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    if (!ready[i]) begin
      check({name, " ready timeout"}, 32'(0), 32'(1));
    end else begin
      check({name, " latency"}, 32'(cyc), 32'(waits[i] + 1));
      check({name, " busy cycles"}, 32'(busy_cyc), 32'(waits[i] + 1));
      check({name, " rdata"}, 32'(rdata[i]), 32'(e.rdata));
      check({name, " err"}, 32'(err[i]), 32'(e.err));
      check({name, " busy at ready"}, 32'(busy[i]), 32'(0));
      @(negedge clk);
      check({name, " ready single pulse"}, 32'(ready[i]), 32'(0));
    end
  endtask

  initial begin
    vec_t vecs [10];
    int   cyc;
    int   first;
    int   nready;
    int   extra;
    exp_t e;

    for (int i = 0; i < N; i++) begin
      reset[i] = 1'b0; memrq[i] = 1'b0; rnw[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d reset rdata", i), 32'(rdata[i]), 32'(0));
      check($sformatf("u%0d reset ready", i), 32'(ready[i]), 32'(0));
      check($sformatf("u%0d reset err", i), 32'(err[i]), 32'(0));
      check($sformatf("u%0d reset busy", i), 32'(busy[i]), 32'(0));
      reset[i] = 1'b1;
    end
    @(negedge clk);
    check("u0 idle after release busy", 32'(busy[0]), 32'(0));

    // WAIT=1: load then read
    load(0, 12'h005, 16'h1234);
    xfer(0, 1'b1, 12'h005, 16'h0000, 16'h1234, 1'b0, "w1 read 005");

    // WAIT=0, DEPTH=2048: table-driven transfers
    load(1, 12'h100, 16'h0042);
    load(1, 12'h7FF, 16'h0ABC);
    load(1, 12'h900, 16'h5A5A);   // out of range: must be dropped
    vecs[0] = '{1'b0, 12'h010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 12'h010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 12'h011, 16'h1234, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 12'h011, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 12'h900, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 12'h900, 16'hFFFF, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 12'h100, 16'h0000, 16'h0042, 1'b0};
    vecs[7] = '{1'b1, 12'h7FF, 16'h0000, 16'h0ABC, 1'b0};
    vecs[8] = '{1'b1, 12'h800, 16'h0000, 16'h0000, 1'b1};
    vecs[9] = '{1'b1, 12'h010, 16'h0000, 16'hBEEF, 1'b0};
    for (int v = 0; v < 10; v++) begin
      xfer(1, vecs[v].rnw, vecs[v].addr, vecs[v].wdata,
           vecs[v].exp_rdata, vecs[v].exp_err, $sformatf("w0 vec%0d", v));
    end

    // Back-to-back with memrq held high, WAIT=1
    load(0, 12'h001, 16'hAAAA);
    load(0, 12'h002, 16'h5555);
    sbq.push_back('{16'hAAAA, 1'b0});
    sbq.push_back('{16'h5555, 1'b0});
    memrq[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 12'h001;
    first = -1; nready = 0;
    for (int c = 0; c < 20 && nready < 2; c++) begin
      @(negedge clk);
      if (ready[0]) begin
        e = sbq.pop_front();
        check($sformatf("b2b rdata %0d", nready), 32'(rdata[0]), 32'(e.rdata));
        if (nready == 0) begin
          first    = c;
          addr[0]  = 12'h002;
        end else begin
          check("b2b ready spacing", 32'(c - first), 32'(3));
          memrq[0] = 1'b0;
        end
        nready++;
      end
    end
    memrq[0] = 1'b0;
    check("b2b ready count", 32'(nready), 32'(2));
    while (sbq.size() > 0) e = sbq.pop_front();
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready[0]) extra++;
    end
    check("b2b no extra ready", 32'(extra), 32'(0));

    // Simultaneous ld_en and memrq in IDLE: load first, read one cycle late
    sbq.push_back('{16'h7777, 1'b0});
    ld_en[0] = 1'b1; ld_addr[0] = 12'h020; ld_data[0] = 16'h7777;
    memrq[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 12'h020;
    @(negedge clk);
    ld_en[0] = 1'b0;
    check("ld+rq idle during load", 32'(busy[0]), 32'(0));
    @(negedge clk);
    memrq[0] = 1'b0;
    cyc = 1;
    while (!ready[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    check("ld+rq latency", 32'(cyc), 32'(3));
    check("ld+rq rdata", 32'(rdata[0]), 32'(e.rdata));

    // Reset mid-transfer, WAIT=3
    load(2, 12'h030, 16'h2222);
    memrq[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 12'h030; wdata[2] = 16'h1111;
    @(negedge clk);
    memrq[2] = 1'b0;
    check("abort busy in wait", 32'(busy[2]), 32'(1));
    @(negedge clk);
    reset[2] = 1'b0;
    #1;
    check("abort busy cleared async", 32'(busy[2]), 32'(0));
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready[2]) extra++;
    end
    reset[2] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ready[2]) extra++;
    end
    check("abort no ready", 32'(extra), 32'(0));
    xfer(2, 1'b1, 12'h030, 16'h0000, 16'h2222, 1'b0, "abort readback");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
